// File: rtl/synth_pkg.sv
// Shared types and the quarter-sine table builder for the wave_synth_gen tone generator.
package synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SAW    = 2'd3
   } wave_sel_t;

   typedef logic signed [7:0] sample8_t;

   localparam int unsigned SINE_AMP    = 127;
   localparam int unsigned TAYLOR_TERM = 9;

   // Entry idx of round(127*sin(2*pi*idx/2^addr_w)), idx in [0, 2^addr_w/4]; Taylor series keeps it elaboration-time.
   function automatic logic [6:0] quarter_sine(input int unsigned addr_w, input int unsigned idx);
      real x;
      real term;
      real acc;
      x    = 6.283185307179586 * real'(idx) / real'(64'd1 << addr_w);
      term = x;
      acc  = x;
      for (int k = 1; k < TAYLOR_TERM; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      return 7'($rtoi(real'(SINE_AMP) * acc + 0.5));
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an active-low raw key plus a registered one-cycle press (falling-edge) pulse.
module key_edge_sync (
   input  logic clk,
   input  logic resetN,
   input  logic key_n,
   output logic fall
);

   logic sync1;
   logic sync2;
   logic prev;

   // All stages reset to the released (high) level so no spurious press appears after reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
         fall  <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         prev  <= sync2;
         fall  <= prev & ~sync2;
      end
   end

endmodule

// File: rtl/wave_synth_gen.sv
// Phase-accumulator tone generator (sine/square/triangle/saw) with debounced volume keys and 2-stage output.
// Optional build macro SYNTH_FADE_EN: scaler level ramps one step per sample_en toward the target volume.
module wave_synth_gen
   import synth_pkg::*;
#(
   parameter int unsigned PHASE_W    = 24,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned OUT_W      = 16,
   parameter int unsigned VOL_LEVELS = 8
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          sample_en,
   input  logic                          enable,
   input  logic                          phase_sync,
   input  logic [PHASE_W-1:0]            tune_word,
   input  logic [1:0]                    wave_sel,
   input  logic                          vol_up,
   input  logic                          vol_down,
   output logic [OUT_W-1:0]              Q,
   output logic                          Q_valid,
   output logic [$clog2(VOL_LEVELS)-1:0] volume_level
);

   localparam int unsigned LVL_W      = $clog2(VOL_LEVELS);
   localparam int unsigned N_ENTRIES  = 1 << ADDR_W;
   localparam int unsigned QUARTER    = N_ENTRIES / 4;
   localparam int unsigned ROM_DEPTH  = QUARTER + 1;
   localparam int unsigned IDX_W      = ADDR_W - 1;
   localparam int unsigned SHIFT_BIAS = OUT_W + 1 - VOL_LEVELS;
   localparam int unsigned EXT_W      = OUT_W - 8;
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(VOL_LEVELS - 1);

   logic [PHASE_W-1:0] phase;
   sample8_t           s8;
   logic               s1_valid;

   logic [6:0]         sine_rom [ROM_DEPTH];

   logic [ADDR_W-1:0]  addr_c;
   logic [1:0]         quad_c;
   logic [ADDR_W-3:0]  qa_c;
   logic [IDX_W-1:0]   rom_idx_c;
   sample8_t           sine_mag_c;
   sample8_t           sine_c;
   sample8_t           square_c;
   logic [7:0]         p_c;
   logic [6:0]         tri_u_c;
   sample8_t           tri_c;
   sample8_t           saw_c;
   sample8_t           wave_c;

   logic               up_fall;
   logic               dn_fall;
   logic [LVL_W-1:0]   eff_level_c;

   logic signed [OUT_W-1:0] ext_c;
   logic signed [OUT_W-1:0] scaled_c;
   int unsigned             shift_c;

   // Constant quarter-wave table, folded at elaboration.
   for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign sine_rom[gi] = quarter_sine(ADDR_W, gi);
   end

   // Waveform lookup for the current phase address.
   always_comb begin
      addr_c     = phase[PHASE_W-1 -: ADDR_W];
      quad_c     = addr_c[ADDR_W-1 -: 2];
      qa_c       = addr_c[ADDR_W-3:0];
      rom_idx_c  = quad_c[0] ? (IDX_W'(QUARTER) - {1'b0, qa_c}) : {1'b0, qa_c};
      sine_mag_c = sample8_t'({1'b0, sine_rom[rom_idx_c]});
      sine_c     = quad_c[1] ? -sine_mag_c : sine_mag_c;

      square_c   = addr_c[ADDR_W-1] ? 8'sh81 : 8'sh7F;

      p_c        = addr_c[ADDR_W-1 -: 8];
      tri_u_c    = p_c[7] ? ~p_c[6:0] : p_c[6:0];
      tri_c      = sample8_t'(8'({tri_u_c, 1'b0} - 8'd128));
      saw_c      = sample8_t'(p_c ^ 8'h80);

      wave_c = sine_c;
      case (wave_sel_t'(wave_sel))
         WAVE_SINE:   wave_c = sine_c;
         WAVE_SQUARE: wave_c = square_c;
         WAVE_TRI:    wave_c = tri_c;
         WAVE_SAW:    wave_c = saw_c;
         default:     wave_c = sine_c;
      endcase
   end

   // Stage 1: phase accumulator and raw 8-bit sample, advanced only on the sample strobe.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         phase    <= '0;
         s8       <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= sample_en;
         if (sample_en) begin
            if (!enable) begin
               s8    <= '0;
               phase <= '0;
            end else if (phase_sync) begin
               s8    <= wave_c;
               phase <= '0;
            end else begin
               s8    <= wave_c;
               phase <= phase + tune_word;
            end
         end
      end
   end

   key_edge_sync u_key_up (
      .clk    (clk),
      .resetN (resetN),
      .key_n  (vol_up),
      .fall   (up_fall)
   );

   key_edge_sync u_key_down (
      .clk    (clk),
      .resetN (resetN),
      .key_n  (vol_down),
      .fall   (dn_fall)
   );

   // Saturating target level; simultaneous presses cancel.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         volume_level <= LVL_MAX;
      end else if (up_fall && !dn_fall && volume_level != LVL_MAX) begin
         volume_level <= volume_level + LVL_W'(1);
      end else if (dn_fall && !up_fall && volume_level != '0) begin
         volume_level <= volume_level - LVL_W'(1);
      end
   end

`ifdef SYNTH_FADE_EN
   logic [LVL_W-1:0] eff_level;

   // Ramp the applied level one step per sample toward the target to avoid clicks.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         eff_level <= LVL_MAX;
      end else if (sample_en) begin
         if (eff_level < volume_level) begin
            eff_level <= eff_level + LVL_W'(1);
         end else if (eff_level > volume_level) begin
            eff_level <= eff_level - LVL_W'(1);
         end
      end
   end

   assign eff_level_c = eff_level;
`else
   assign eff_level_c = volume_level;
`endif

   // 6 dB per level: sign-extended sample shifted so the top level fills the output width.
   always_comb begin
      ext_c    = {{EXT_W{s8[7]}}, s8};
      shift_c  = 32'(eff_level_c) + SHIFT_BIAS - 32'd8;
      scaled_c = '0;
      if (eff_level_c != '0) begin
         scaled_c = ext_c <<< shift_c;
      end
   end

   // Stage 2: registered output sample and one-cycle valid.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         Q       <= '0;
         Q_valid <= 1'b0;
      end else begin
         Q_valid <= s1_valid;
         if (s1_valid) begin
            Q <= scaled_c;
         end
      end
   end

endmodule

// File: tb/tb_wave_synth_gen.sv
// Scoreboard bench for wave_synth_gen: stimulus queues expected samples, a negedge monitor checks each Q_valid.
module tb_wave_synth_gen;

   logic        clk;
   logic        resetN;
   logic        sample_en;
   logic        enable;
   logic        phase_sync;
   logic [23:0] tune_word;
   logic [1:0]  wave_sel;
   logic        vol_up;
   logic        vol_down;
   logic [15:0] Q;
   logic        Q_valid;
   logic [2:0]  volume_level;

   int          checks;
   int          failures;
   logic [15:0] exp_q[$];
   logic [15:0] exp_v;

   localparam logic [1:0] SEL_SINE = 2'd0;
   localparam logic [1:0] SEL_SQR  = 2'd1;
   localparam logic [1:0] SEL_TRI  = 2'd2;
   localparam logic [1:0] SEL_SAW  = 2'd3;

   wave_synth_gen dut (
      .clk          (clk),
      .resetN       (resetN),
      .sample_en    (sample_en),
      .enable       (enable),
      .phase_sync   (phase_sync),
      .tune_word    (tune_word),
      .wave_sel     (wave_sel),
      .vol_up       (vol_up),
      .vol_down     (vol_down),
      .Q            (Q),
      .Q_valid      (Q_valid),
      .volume_level (volume_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (Q_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid got Q=0x%0h expected no valid at %0t", Q, $time);
         end else begin
            exp_v = exp_q.pop_front();
            check("sample_q", 32'(Q), 32'(exp_v));
         end
      end
   end

   // One strobe; controls are scrambled afterwards since they matter only on the strobe cycle.
   task automatic do_sample(input logic en, input logic sync, input logic [1:0] sel,
                            input logic [23:0] tw, input logic [15:0] expected);
      @(negedge clk);
      enable     = en;
      phase_sync = sync;
      wave_sel   = sel;
      tune_word  = tw;
      sample_en  = 1'b1;
      exp_q.push_back(expected);
      @(negedge clk);
      sample_en  = 1'b0;
      phase_sync = 1'b0;
      wave_sel   = sel + 2'd1;
      tune_word  = 24'hFFFFFF;
      enable     = ~en;
      repeat (3) @(negedge clk);
   endtask

   task automatic press(input logic up, input logic dn);
      @(negedge clk);
      if (up) vol_up = 1'b0;
      if (dn) vol_down = 1'b0;
      repeat (6) @(negedge clk);
      vol_up   = 1'b1;
      vol_down = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      resetN     = 1'b0;
      sample_en  = 1'b0;
      enable     = 1'b0;
      phase_sync = 1'b0;
      tune_word  = '0;
      wave_sel   = SEL_SINE;
      vol_up     = 1'b1;
      vol_down   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_q", 32'(Q), 32'h0);
      check("reset_valid", 32'(Q_valid), 32'h0);
      check("reset_level", 32'(volume_level), 32'd7);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      // Fine pitch sine, then phase_sync behaviour
      do_sample(1, 0, SEL_SINE, 24'h010000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h010000, 16'h0300);
      do_sample(1, 0, SEL_SINE, 24'h010000, 16'h0600);
      do_sample(1, 1, SEL_SINE, 24'h010000, 16'h0900);
      do_sample(1, 1, SEL_SINE, 24'h010000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h010000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h010000, 16'h0300);
      do_sample(0, 0, SEL_SINE, 24'h010000, 16'h0000);

      // Quadrant points of sine and square
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h7F00);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h8100);
      do_sample(1, 0, SEL_SQR,  24'h400000, 16'h7F00);
      do_sample(1, 0, SEL_SQR,  24'h400000, 16'h7F00);
      do_sample(1, 0, SEL_SQR,  24'h400000, 16'h8100);
      do_sample(1, 0, SEL_SQR,  24'h400000, 16'h8100);
      do_sample(0, 0, SEL_SQR,  24'h400000, 16'h0000);

      // Triangle and saw extremes
      do_sample(1, 0, SEL_TRI,  24'h7F0000, 16'h8000);
      do_sample(1, 0, SEL_TRI,  24'h7F0000, 16'h7E00);
      do_sample(1, 0, SEL_TRI,  24'h7F0000, 16'h8200);
      do_sample(0, 0, SEL_TRI,  24'h7F0000, 16'h0000);
      do_sample(1, 0, SEL_SAW,  24'hFF0000, 16'h8000);
      do_sample(1, 0, SEL_SAW,  24'hFF0000, 16'h7F00);
      do_sample(0, 0, SEL_SAW,  24'hFF0000, 16'h0000);

      // Volume down to mute, then one step up
      for (int i = 0; i < 9; i++) press(0, 1);
      check("level_min", 32'(volume_level), 32'd0);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      press(1, 0);
      check("level_one", 32'(volume_level), 32'd1);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'hFE04);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h01FC);

      // Saturate at the top, then level 5 and simultaneous keys
      for (int i = 0; i < 9; i++) press(1, 0);
      check("level_max", 32'(volume_level), 32'd7);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h8100);
      press(0, 1);
      press(0, 1);
      check("level_five", 32'(volume_level), 32'd5);
      press(1, 1);
      check("level_both_keys", 32'(volume_level), 32'd5);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h1FC0);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'hE040);

      // Reset between stage 1 and stage 2 drops the pending sample
      @(negedge clk);
      enable    = 1'b1;
      wave_sel  = SEL_SINE;
      tune_word = 24'h400000;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      resetN    = 1'b0;
      @(negedge clk);
      check("midreset_q", 32'(Q), 32'h0);
      check("midreset_valid", 32'(Q_valid), 32'h0);
      check("midreset_level", 32'(volume_level), 32'd7);
      resetN = 1'b1;
      repeat (4) @(negedge clk);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h0000);
      do_sample(1, 0, SEL_SINE, 24'h400000, 16'h7F00);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_samples", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
